instr_fetch_unit: RTL and testbench

- Supplies the 19-bit instruction stream to the execution core. The core consumes instructions; this block produces them.
- Owns a program memory that is loaded word-by-word while idle.
- Fetches sequentially from a start PC into a small prefetch FIFO, and presents instructions to the core with a valid/ready handshake.
- On a core redirect (jump/branch/call/ret), flushes the FIFO and refetches from the new PC.

---
 rtl/instr_fetch_unit.sv | 219 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end for the execution core.
//               Holds a program memory (loadable while idle), fetches
//               sequentially from a start PC into a small prefetch FIFO and
//               presents 19-bit instructions to the core over a
//               valid/ready handshake. A core redirect flushes the FIFO and
//               refetches from the new PC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   AW          program memory address width (depth = 2**AW words)
//   FIFO_DEPTH  prefetch FIFO entries (power of two, >= 2)
//   KEY         instruction XOR key (optional decrypt build only)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_en/addr/data          program write port, honoured in IDLE
//   start, start_pc            begin fetching at start_pc (IDLE only)
//   stop                       flush and return to IDLE (RUN only)
//   redirect_valid/pc          flush and refetch from redirect_pc (RUN only)
//   instr, instr_pc            FIFO head word and its address
//   instr_valid, instr_ready   output handshake
//   busy                       high while in RUN
// Build option:
//   INSTR_DECRYPT_EN  when defined, every fetched word is XORed with KEY
//                     before it enters the FIFO.
// ============================================================================
module instr_fetch_unit #(
   parameter int          AW         = 10,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [18:0] KEY        = 19'h0ABCD
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [18:0]   load_data,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   input  logic          stop,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic [18:0]   instr,
   output logic [AW-1:0] instr_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic          busy
);

   localparam int IW = 19;
   localparam int PW = $clog2(FIFO_DEPTH);   // pointer width
   localparam int CW = PW + 1;               // count width, holds 0..FIFO_DEPTH
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   // Program memory and its registered read port
   logic [IW-1:0] mem [0:(2**AW)-1];
   logic [IW-1:0] rd_data;
   logic [AW-1:0] rd_pc;

   // Fetch control
   logic [AW-1:0] fetch_pc;
   logic          in_flight;

   // Prefetch FIFO
   logic [IW-1:0] fifo_data [0:FIFO_DEPTH-1];
   logic [AW-1:0] fifo_pc   [0:FIFO_DEPTH-1];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          flush;
   logic          issue;
   logic          push;
   logic          pop;
   logic [IW-1:0] push_data;

   // -------------------------------------------------------------------------
   // State machine
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Handshake and credit decode
   // -------------------------------------------------------------------------
   // A read may only be issued if its result is guaranteed a FIFO slot:
   // entries already held plus the one result still in the memory pipeline
   // must leave room. Using the pre-pop count is conservative but still
   // sustains one instruction per cycle once the pipeline is primed.
   always_comb begin
      flush = (state == RUN) && (redirect_valid || stop);
      issue = (state == RUN) && !redirect_valid && !stop &&
              ((count + CW'(in_flight)) < DEPTH_CNT);
      push  = in_flight && !flush;
      pop   = instr_valid && instr_ready && !flush;
   end

`ifdef INSTR_DECRYPT_EN
   assign push_data = rd_data ^ KEY;
`else
   // The key is masked to zero so the word passes through unchanged while
   // the parameter remains referenced in this build as well.
   assign push_data = rd_data ^ (KEY & {IW{1'b0}});
`endif

   // -------------------------------------------------------------------------
   // Program memory: no reset, so contents survive rst_n
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if ((state == IDLE) && load_en) begin
         mem[load_addr] <= load_data;
      end
      if (issue) begin
         rd_data <= mem[fetch_pc];
         rd_pc   <= fetch_pc;
      end
   end

   // -------------------------------------------------------------------------
   // Fetch PC and in-flight tracking
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc  <= '0;
         in_flight <= 1'b0;
      end else if (state == IDLE) begin
         in_flight <= 1'b0;
         if (start) begin
            fetch_pc <= start_pc;
         end
      end else if (flush) begin
         // Any read already issued is abandoned; stop wins over redirect.
         in_flight <= 1'b0;
         if (!stop) begin
            fetch_pc <= redirect_pc;
         end
      end else begin
         in_flight <= issue;
         if (issue) begin
            fetch_pc <= fetch_pc + AW'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Prefetch FIFO
   // -------------------------------------------------------------------------
   // Storage is reset so the head reads as zero while rst_n is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else if (flush) begin
         // Keep the read pointer so the stale head (a don't-care) stays put.
         wr_ptr <= rd_ptr;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_pc[wr_ptr]   <= rd_pc;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign instr       = fifo_data[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];
   assign instr_valid = (count != '0);
   assign busy        = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. Covers
//               reset values, start latency, streaming, back-pressure,
//               redirect flush, PC wrap, reset mid-run with memory retention,
//               and simultaneous load+start (with the decrypt build option
//               INSTR_DECRYPT_EN reflected in the expected words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [18:0]   load_data;
   logic          start;
   logic [AW-1:0] start_pc;
   logic          stop;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic [18:0]   instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .AW         (AW),
      .FIFO_DEPTH (4),
      .KEY        (19'h0ABCD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .start          (start),
      .start_pc       (start_pc),
      .stop           (stop),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .busy           (busy)
   );

   // Program image: test-plan words at 0..3, a PC-derived pattern elsewhere.
   function automatic logic [18:0] prog(input logic [AW-1:0] a);
      case (a)
         10'd0:   return 19'h02001;
         10'd1:   return 19'h02202;
         10'd2:   return 19'h12400;
         10'd3:   return 19'h04003;
         default: return {9'h0A5, a};
      endcase
   endfunction

   // Word as the core should see it after the optional decrypt.
   function automatic logic [18:0] seen(input logic [18:0] w);
`ifdef INSTR_DECRYPT_EN
      return w ^ 19'h0ABCD;
`else
      return w;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a);
      load_en   = 1'b1;
      load_addr = a;
      load_data = prog(a);
      tick();
      load_en   = 1'b0;
   endtask

   task automatic do_start(input logic [AW-1:0] pc);
      start    = 1'b1;
      start_pc = pc;
      tick();
      start    = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      load_en        = 1'b0;
      load_addr      = '0;
      load_data      = '0;
      start          = 1'b0;
      start_pc       = '0;
      stop           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;

      // ---- Reset values ----
      tick();
      tick();
      check("rst_instr", 32'(instr), 32'h0);
      check("rst_pc", 32'(instr_pc), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();

      // ---- Load program ----
      for (int a = 0; a < 8; a++) load(AW'(a));
      for (int a = 10'h200; a < 10'h204; a++) load(AW'(a));
      load(10'h3FE);
      load(10'h3FF);
      check("idle_busy", 32'(busy), 32'h0);

      // ---- Start latency and streaming ----
      instr_ready = 1'b1;
      do_start(10'h000);
      check("lat_k", 32'(instr_valid), 32'h0);
      check("lat_busy", 32'(busy), 32'h1);
      tick();
      check("lat_k1", 32'(instr_valid), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("str_valid", 32'(instr_valid), 32'h1);
         check("str_pc", 32'(instr_pc), 32'(i));
         check("str_instr", 32'(instr), 32'(seen(prog(AW'(i)))));
         tick();
      end
      do_stop();
      check("stop_busy", 32'(busy), 32'h0);
      check("stop_valid", 32'(instr_valid), 32'h0);

      // ---- Back-pressure ----
      instr_ready = 1'b0;
      do_start(10'h000);
      repeat (10) tick();
      check("bp_valid", 32'(instr_valid), 32'h1);
      check("bp_instr", 32'(instr), 32'(seen(19'h02001)));
      check("bp_pc", 32'(instr_pc), 32'h0);
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_rel_valid", 32'(instr_valid), 32'h1);
         check("bp_rel_pc", 32'(instr_pc), 32'(i));
         check("bp_rel_instr", 32'(instr), 32'(seen(prog(AW'(i)))));
         tick();
      end
      do_stop();

      // ---- Redirect while FIFO holds PCs 1..4 ----
      instr_ready = 1'b0;
      do_start(10'h000);
      repeat (10) tick();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      tick();
      check("rd_pre_pc", 32'(instr_pc), 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 10'h200;
      instr_ready    = 1'b1;
      tick();
      redirect_valid = 1'b0;
      check("rd_r0_valid", 32'(instr_valid), 32'h0);
      tick();
      check("rd_r1_valid", 32'(instr_valid), 32'h0);
      tick();
      check("rd_r2_valid", 32'(instr_valid), 32'h1);
      check("rd_r2_pc", 32'(instr_pc), 32'h200);
      check("rd_r2_instr", 32'(instr), 32'(seen(prog(10'h200))));
      tick();
      check("rd_r3_pc", 32'(instr_pc), 32'h201);
      do_stop();

      // ---- PC wrap ----
      instr_ready = 1'b1;
      do_start(10'h3FE);
      tick();
      tick();
      check("wr_pc0", 32'(instr_pc), 32'h3FE);
      check("wr_instr0", 32'(instr), 32'(seen(prog(10'h3FE))));
      tick();
      check("wr_pc1", 32'(instr_pc), 32'h3FF);
      tick();
      check("wr_pc2", 32'(instr_pc), 32'h000);
      check("wr_instr2", 32'(instr), 32'(seen(19'h02001)));
      tick();
      check("wr_pc3", 32'(instr_pc), 32'h001);

      // ---- Reset mid-RUN, memory retained ----
      rst_n = 1'b0;
      #1;
      check("mr_instr", 32'(instr), 32'h0);
      check("mr_pc", 32'(instr_pc), 32'h0);
      check("mr_valid", 32'(instr_valid), 32'h0);
      check("mr_busy", 32'(busy), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      do_start(10'h000);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         check("mr_run_pc", 32'(instr_pc), 32'(i));
         check("mr_run_instr", 32'(instr), 32'(seen(prog(AW'(i)))));
         tick();
      end
      do_stop();

      // ---- Load and start in the same cycle; key word at PC 0 ----
      load_en   = 1'b1;
      load_addr = 10'h000;
      load_data = 19'h0ABCD;
      start     = 1'b1;
      start_pc  = 10'h000;
      tick();
      load_en   = 1'b0;
      start     = 1'b0;
      check("ls_busy", 32'(busy), 32'h1);
      tick();
      tick();
      check("ls_pc", 32'(instr_pc), 32'h0);
      check("ls_instr", 32'(instr), 32'(seen(19'h0ABCD)));
      tick();
      check("ls_pc1", 32'(instr_pc), 32'h1);
      do_stop();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
